// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and parity-mode constants
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam bit UART_PARITY_EVEN = 1'b0;
  localparam bit UART_PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// rtl/rx_bit_counter.sv - saturating down-counter of data bits left in a frame
module rx_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // zero reflects the post-update count so the FSM can leave DATA on the last sample edge
  always_comb begin
    if (load) begin
      zero = (load_val == '0);
    end else if (dec) begin
      zero = (cnt <= W'(1));
    end else begin
      zero = (cnt == '0);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity and framing checks
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = UART_PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  uart_rx_state_t state, state_n;
  logic rx_meta, rx_s, rx_prev;
  logic [CW-1:0] os_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic par_bad;
  logic cnt_clr, bit_load, bit_dec, bit_zero, shift_en, par_chk, stop_chk;

  rx_bit_counter #(.W(BW)) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load),
    .dec      (bit_dec),
    .load_val (BW'(DATA_BITS)),
    .zero     (bit_zero)
  );

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    shift_en = 1'b0;
    par_chk  = 1'b0;
    stop_chk = 1'b0;
    case (state)
      // a falling edge is required, so a line held low after a break never restarts
      ST_IDLE: if (rx_prev && !rx_s) begin
        state_n = ST_START;
        cnt_clr = 1'b1;
      end
      ST_START: if (tick_16x && os_cnt == MID) begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          state_n  = ST_DATA;
          bit_load = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: if (tick_16x && os_cnt == LAST) begin
        shift_en = 1'b1;
        bit_dec  = 1'b1;
        if (bit_zero) begin
          cnt_clr = 1'b1;
          state_n = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tick_16x && os_cnt == LAST) begin
        par_chk = 1'b1;
        cnt_clr = 1'b1;
        state_n = ST_STOP;
      end
      ST_STOP: if (tick_16x && os_cnt == LAST) begin
        stop_chk = 1'b1;
        cnt_clr  = 1'b1;
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= ST_IDLE;
      os_cnt     <= '0;
      shift_q    <= '0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      state      <= state_n;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (cnt_clr) begin
        os_cnt <= '0;
      end else if (tick_16x && state != ST_IDLE) begin
        os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + CW'(1);
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      end
      if (bit_load) begin
        par_bad <= 1'b0;
      end else if (par_chk) begin
        par_bad <= (rx_s != ((^shift_q) ^ PARITY_ODD));
      end
      if (stop_chk) begin
        if (rx_s) begin
          data_out   <= shift_q;
          data_valid <= 1'b1;
          parity_err <= par_bad;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
